// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: derives SCLK/LRCLK from MCLK and shifts each
// captured stereo sample out MSB-first, one SCLK after the LRCLK edge,
// zero-padded to the end of its slot.
module i2s_tx_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_BITS  = 32,
    parameter int SCLK_DIV   = 4
) (
    input  logic                  MCLK,
    input  logic                  RESET_N,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] LEFT_TX,
    input  logic [DATA_WIDTH-1:0] RIGHT_TX,
    output logic                  SCLK,
    output logic                  LRCLK,
    output logic                  SDATA,
    output logic                  FRAME_LOAD,
    output logic                  BUSY
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DW         = $clog2(SCLK_DIV);
    localparam int BW         = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  sclk_q, sclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
    logic                  load_q, load_d, busy_q, busy_d;

    logic                  fall, wrap, nxt_lr, sd_nxt;
    logic [BW-1:0]         nxt_bit, nxt_slot;
    logic [DATA_WIDTH-1:0] word_sel;

    // A falling SCLK edge happens when the divider wraps; a frame wraps on the
    // falling edge that leaves the last bit of the right slot.
    assign fall     = (div_q == DW'(SCLK_DIV - 1));
    assign wrap     = fall && (bit_q == BW'(FRAME_BITS - 1));
    assign nxt_bit  = (bit_q == BW'(FRAME_BITS - 1)) ? '0 : bit_q + BW'(1);
    assign nxt_lr   = (nxt_bit >= BW'(SLOT_BITS));
    assign nxt_slot = nxt_lr ? nxt_bit - BW'(SLOT_BITS) : nxt_bit;

    // Data bit for the upcoming slot position: slot bit b carries hold[DATA_WIDTH-b].
    always_comb begin
        sd_nxt   = 1'b0;
        word_sel = nxt_lr ? right_q : left_q;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (int'(nxt_slot) == DATA_WIDTH - i) sd_nxt = word_sel[i];
        end
    end

    // Next-state, counters, hold capture and registered output values.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        left_d  = left_q;
        right_d = right_q;
        sclk_d  = sclk_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        load_d  = 1'b0;
        case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                sclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (ENABLE) begin
                    state_d = RUN;
                    left_d  = LEFT_TX;
                    right_d = RIGHT_TX;
                    load_d  = 1'b1;
                end
            end
            default: begin
                div_d = fall ? '0 : div_q + DW'(1);
                if (fall)                         sclk_d = 1'b0;
                else if (div_d == DW'(SCLK_DIV / 2)) sclk_d = 1'b1;
                if (state_q == RUN && !ENABLE)  state_d = DRAIN;
                if (state_q == DRAIN && ENABLE) state_d = RUN;
                if (fall) begin
                    bit_d   = nxt_bit;
                    lrclk_d = nxt_lr;
                    sdata_d = sd_nxt;
                end
                if (wrap) begin
                    // Enable seen on a draining wrap keeps the stream going.
                    if (state_q == RUN || ENABLE) begin
                        left_d  = LEFT_TX;
                        right_d = RIGHT_TX;
                        load_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        div_d   = '0;
                        bit_d   = '0;
                        sclk_d  = 1'b0;
                        lrclk_d = 1'b0;
                        sdata_d = 1'b0;
                    end
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge MCLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            left_q  <= left_d;
            right_q <= right_d;
            sclk_q  <= sclk_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    assign SCLK       = sclk_q;
    assign LRCLK      = lrclk_q;
    assign SDATA      = sdata_q;
    assign FRAME_LOAD = load_q;
    assign BUSY       = busy_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: stimulus queues expected load
// cycles and slot words, a monitor reassembles slots at SCLK rising edges.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

    logic        MCLK = 1'b0;
    logic        RESET_N, ENABLE;
    logic [23:0] LEFT_TX, RIGHT_TX;
    logic        SCLK, LRCLK, SDATA, FRAME_LOAD, BUSY;

    i2s_tx_serializer dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .ENABLE(ENABLE),
        .LEFT_TX(LEFT_TX), .RIGHT_TX(RIGHT_TX),
        .SCLK(SCLK), .LRCLK(LRCLK), .SDATA(SDATA),
        .FRAME_LOAD(FRAME_LOAD), .BUSY(BUSY)
    );

    always #5 MCLK = ~MCLK;

    int cyc = 0;
    always @(posedge MCLK) cyc <= cyc + 1;

    int          checks = 0, errors = 0;
    int          load_q[$];
    logic [32:0] slot_q[$];

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_slot(input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL slot_word: got %h expected %h (cycle %0d)", act, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string name);
        chk_int(name, int'({SCLK, LRCLK, SDATA, FRAME_LOAD, BUSY}), 0);
    endtask

    // Expected slot = {lrclk, b0=0, sample bits b1..b24, 7 zero pad bits}.
    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        slot_q.push_back({1'b0, 1'b0, l, 7'b0});
        slot_q.push_back({1'b1, 1'b0, r, 7'b0});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge MCLK);
    endtask

    // Monitor: frame loads, slot reassembly, SCLK/LRCLK half-periods.
    int          cnt = 0, last_sclk = 0, last_lr = 0;
    bit          sclk_arm = 0, lr_arm = 0;
    logic        psclk = 1'b0, plr = 1'b0;
    logic [31:0] sh = '0;
    initial forever begin
        @(negedge MCLK);
        if (BUSY !== 1'b1) begin
            cnt = 0; sclk_arm = 0; lr_arm = 0;
        end
        if (FRAME_LOAD === 1'b1) begin
            if (load_q.size() == 0) chk_int("unexpected_frame_load", cyc, -1);
            else                    chk_int("frame_load_cycle", cyc, load_q.pop_front());
            cnt = 0;
        end
        if (BUSY === 1'b1 && SCLK === 1'b1 && psclk === 1'b0) begin
            sh = {sh[30:0], SDATA};
            cnt++;
            if (cnt == 32) begin
                cnt = 0;
                if (slot_q.size() == 0) chk_int("unexpected_slot", cyc, -1);
                else                    chk_slot({LRCLK, sh}, slot_q.pop_front());
            end
        end
        if (BUSY === 1'b1 && SCLK !== psclk) begin
            if (sclk_arm) chk_int("sclk_half_period", cyc - last_sclk, 2);
            last_sclk = cyc; sclk_arm = 1;
        end
        if (BUSY === 1'b1 && LRCLK !== plr) begin
            if (lr_arm) chk_int("lrclk_half_period", cyc - last_lr, 128);
            last_lr = cyc; lr_arm = 1;
        end
        psclk = SCLK;
        plr   = LRCLK;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int k;
    initial begin
        // Reset held with enable and all-ones input: outputs stay 0.
        RESET_N = 1'b0; ENABLE = 1'b1; LEFT_TX = 24'hFFFFFF; RIGHT_TX = 24'h000000;
        repeat (4) @(negedge MCLK);
        chk_idle("reset_outputs");
        k = cyc; RESET_N = 1'b1;
        load_q.push_back(k + 1); push_frame(24'hFFFFFF, 24'h000000);
        wait_cyc(k + 1); chk_int("busy_rise", int'(BUSY), 1);
        wait_cyc(k + 2); ENABLE = 1'b0;
        wait_cyc(k + 256); chk_int("busy_before_wrap", int'(BUSY), 1);
        wait_cyc(k + 257); chk_idle("idle_after_drain_1");

        // Bit order and clocking over three frames.
        wait_cyc(k + 270);
        LEFT_TX = 24'h800001; RIGHT_TX = 24'h7FFFFE;
        k = cyc; ENABLE = 1'b1;
        for (int f = 0; f < 3; f++) begin
            load_q.push_back(k + 1 + 256 * f);
            push_frame(24'h800001, 24'h7FFFFE);
        end
        wait_cyc(k + 600); ENABLE = 1'b0;
        wait_cyc(k + 770); chk_idle("idle_after_drain_2");

        // Mid-frame input change, then drain from frame cycle 100.
        LEFT_TX = 24'h123456; RIGHT_TX = 24'h654321;
        k = cyc; ENABLE = 1'b1;
        load_q.push_back(k + 1);   push_frame(24'h123456, 24'h654321);
        load_q.push_back(k + 257); push_frame(24'hABCDEF, 24'h654321);
        wait_cyc(k + 50);  LEFT_TX = 24'hABCDEF;
        wait_cyc(k + 357); ENABLE = 1'b0;
        wait_cyc(k + 513); chk_idle("idle_after_drain_3");

        // Drain cancelled by re-enable at frame cycle 180.
        wait_cyc(k + 520);
        LEFT_TX = 24'h5A5A5A; RIGHT_TX = 24'hC3C3C3;
        k = cyc; ENABLE = 1'b1;
        load_q.push_back(k + 1);   push_frame(24'h5A5A5A, 24'hC3C3C3);
        load_q.push_back(k + 257); push_frame(24'h111111, 24'h222222);
        wait_cyc(k + 100); ENABLE = 1'b0;
        wait_cyc(k + 180); ENABLE = 1'b1;
        wait_cyc(k + 200); LEFT_TX = 24'h111111; RIGHT_TX = 24'h222222;
        wait_cyc(k + 256); chk_int("busy_through_reenable", int'(BUSY), 1);
        wait_cyc(k + 300); ENABLE = 1'b0;
        wait_cyc(k + 513); chk_idle("idle_after_drain_4");

        // Reset at frame cycle 70, then a fresh frame.
        wait_cyc(k + 520);
        LEFT_TX = 24'hFEDCBA; RIGHT_TX = 24'h13579B;
        k = cyc; ENABLE = 1'b1;
        load_q.push_back(k + 1);
        wait_cyc(k + 70); RESET_N = 1'b0;
        wait_cyc(k + 71); chk_idle("midframe_reset_outputs");
        LEFT_TX = 24'h0F0F0F; RIGHT_TX = 24'hF0F0F0;
        wait_cyc(k + 73);
        k = cyc; RESET_N = 1'b1;
        load_q.push_back(k + 1); push_frame(24'h0F0F0F, 24'hF0F0F0);
        wait_cyc(k + 10);  ENABLE = 1'b0;
        wait_cyc(k + 257); chk_idle("idle_after_restart");

        wait_cyc(k + 300);
        chk_int("loads_outstanding", load_q.size(), 0);
        chk_int("slots_outstanding", slot_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
